// File: rtl/multicycle_controller_if.sv
// Handshake/control bundle between the multicycle controller and its datapath.
// The master modport is the controller side, and the slave modport is the datapath side.
interface multicycle_controller_if;
   logic [6:0] Op;
   logic       MemReady;
   logic       MemReq;
   logic       PCUpdate;
   logic       Branch;
   logic       IRWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic       AdrSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [1:0] ALUOp;
   logic [2:0] ImmSrc;
   logic       InstrDone;
   logic       IllegalInstr;
   logic       BusErr;

   modport master (
      input  Op, MemReady,
      output MemReq, PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc, InstrDone, IllegalInstr, BusErr
   );

   modport slave (
      output Op, MemReady,
      input  MemReq, PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc, InstrDone, IllegalInstr, BusErr
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit. A Moore FSM steps one instruction through a shared
// memory/ALU datapath. It adds a memory-ready handshake, a wait-timeout watchdog,
// optional LUI/AUIPC decode, and sticky traps for illegal opcodes and bus timeouts.
module multicycle_controller #(
   parameter bit          EN_UTYPE    = 1'b1,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   multicycle_controller_if.master bus
);

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   // A disabled watchdog still keeps a 1-bit counter, so no declaration has zero width.
   localparam int unsigned CNT_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam int unsigned LAST_I   = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTER,
      S_EXECUTEI, S_LUI, S_AUIPC, S_ALUWB, S_BEQ, S_JAL, S_TRAP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;

   logic       mem_wait;
   logic       mem_req, pc_update, branch, ir_write, reg_write, mem_write, instr_done;
   logic       adr_src;
   logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
   logic [2:0] imm_src;

   // A memory stall is any cycle that requests memory while ready is low.
   assign mem_wait = (state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE}) && !bus.MemReady;

   // State register, watchdog counter and sticky trap flags, with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Next-state decode, trap detection and the watchdog count.
   always_comb begin
      // NOTE: every next-state term gets a default first, so no path through the case infers a latch.
      state_d   = state_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      cnt_d     = '0;
      case (state_q)
         S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               OP_LUI:       state_d = EN_UTYPE ? S_LUI : S_TRAP;
               OP_AUIPC:     state_d = EN_UTYPE ? S_AUIPC : S_TRAP;
               default:      state_d = S_TRAP;
            endcase
            if (state_d == S_TRAP) illegal_d = 1'b1;
         end
         S_MEMADR:   state_d = (bus.Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (bus.MemReady) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (bus.MemReady) state_d = S_FETCH;
         S_EXECUTER, S_EXECUTEI, S_LUI, S_AUIPC: state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
      // The last allowed stall cycle traps. MemReady in that cycle leaves mem_wait low and wins.
      if (MEM_TIMEOUT != 0 && mem_wait && cnt_q == CNT_LAST) begin
         state_d   = S_TRAP;
         bus_err_d = 1'b1;
      end
      if (MEM_TIMEOUT != 0 && mem_wait && state_d == state_q) cnt_d = cnt_q + CNT_W'(1);
   end

   // Moore outputs per state. Enables are masked while reset is held.
   always_comb begin
      mem_req    = 1'b0;
      pc_update  = 1'b0;
      branch     = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      alu_op     = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = bus.MemReady;
            pc_update  = bus.MemReady;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req    = 1'b1;
            adr_src    = 1'b1;
            mem_write  = bus.MemReady;
            instr_done = bus.MemReady;
         end
         S_EXECUTER: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         S_EXECUTEI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         S_LUI: begin
            alu_src_a = 2'b11;
            alu_src_b = 2'b01;
         end
         S_AUIPC: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_BEQ: begin
            alu_src_a  = 2'b10;
            alu_op     = 2'b01;
            branch     = 1'b1;
            instr_done = 1'b1;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
         end
         default: ;
      endcase
      if (!rst_n) begin
         mem_req    = 1'b0;
         pc_update  = 1'b0;
         branch     = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         mem_write  = 1'b0;
         instr_done = 1'b0;
      end
   end

   // Immediate format follows the opcode alone.
   always_comb begin
      case (bus.Op)
         OP_SW:            imm_src = 3'b001;
         OP_BEQ:           imm_src = 3'b010;
         OP_JAL:           imm_src = 3'b011;
         OP_LUI, OP_AUIPC: imm_src = 3'b100;
         default:          imm_src = 3'b000;
      endcase
   end

   assign bus.MemReq       = mem_req;
   assign bus.PCUpdate     = pc_update;
   assign bus.Branch       = branch;
   assign bus.IRWrite      = ir_write;
   assign bus.RegWrite     = reg_write;
   assign bus.MemWrite     = mem_write;
   assign bus.AdrSrc       = adr_src;
   assign bus.ALUSrcA      = alu_src_a;
   assign bus.ALUSrcB      = alu_src_b;
   assign bus.ResultSrc    = result_src;
   assign bus.ALUOp        = alu_op;
   assign bus.ImmSrc       = imm_src;
   assign bus.InstrDone    = instr_done;
   assign bus.IllegalInstr = illegal_q;
   assign bus.BusErr       = bus_err_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Two instances share the stimulus:
// dut_a (U-type on, watchdog 4) and dut_b (U-type off, watchdog disabled).
module tb_multicycle_controller;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_BAD   = 7'b1111111;

   typedef enum {
      T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE, T_EXR, T_EXI,
      T_LUI, T_AUIPC, T_ALUWB, T_BEQ, T_JAL, T_TRAP
   } tst_t;

   typedef struct packed {
      logic       mem_req, pc_update, branch, ir_write, reg_write, mem_write, adr_src;
      logic [1:0] src_a, src_b, res_src, alu_op;
      logic       done, ill, bus;
   } out_t;

   typedef struct {
      string      tag;
      out_t       a;
      out_t       b;
      logic [2:0] imm;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic       rdy;
   int         n_tests = 0;
   int         n_fail  = 0;
   logic       ea_ill, ea_bus, eb_ill, eb_bus;
   exp_t       sb_q[$];
   out_t       obs_a, obs_b;

   always #5 clk = ~clk;

   multicycle_controller_if if_a ();
   multicycle_controller_if if_b ();

   assign if_a.Op = op;
   assign if_a.MemReady = rdy;
   assign if_b.Op = op;
   assign if_b.MemReady = rdy;

   multicycle_controller #(.EN_UTYPE(1'b1), .MEM_TIMEOUT(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(if_a.master));
   multicycle_controller #(.EN_UTYPE(1'b0), .MEM_TIMEOUT(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(if_b.master));

   assign obs_a = {if_a.MemReq, if_a.PCUpdate, if_a.Branch, if_a.IRWrite, if_a.RegWrite,
                   if_a.MemWrite, if_a.AdrSrc, if_a.ALUSrcA, if_a.ALUSrcB, if_a.ResultSrc,
                   if_a.ALUOp, if_a.InstrDone, if_a.IllegalInstr, if_a.BusErr};
   assign obs_b = {if_b.MemReq, if_b.PCUpdate, if_b.Branch, if_b.IRWrite, if_b.RegWrite,
                   if_b.MemWrite, if_b.AdrSrc, if_b.ALUSrcA, if_b.ALUSrcB, if_b.ResultSrc,
                   if_b.ALUOp, if_b.InstrDone, if_b.IllegalInstr, if_b.BusErr};

   // Expected controller outputs for a state, taken from the state output table.
   function automatic out_t exp_out(input tst_t s, input logic r, input logic in_rst,
                                    input logic ill, input logic bus);
      out_t o;
      o = '0;
      case (s)
         T_FETCH:    begin o.mem_req = 1; o.src_b = 2'b10; o.res_src = 2'b10;
                           o.ir_write = r; o.pc_update = r; end
         T_DECODE:   begin o.src_a = 2'b01; o.src_b = 2'b01; end
         T_MEMADR:   begin o.src_a = 2'b10; o.src_b = 2'b01; end
         T_MEMREAD:  begin o.mem_req = 1; o.adr_src = 1; end
         T_MEMWB:    begin o.res_src = 2'b01; o.reg_write = 1; o.done = 1; end
         T_MEMWRITE: begin o.mem_req = 1; o.adr_src = 1; o.mem_write = r; o.done = r; end
         T_EXR:      begin o.src_a = 2'b10; o.alu_op = 2'b10; end
         T_EXI:      begin o.src_a = 2'b10; o.src_b = 2'b01; o.alu_op = 2'b10; end
         T_LUI:      begin o.src_a = 2'b11; o.src_b = 2'b01; end
         T_AUIPC:    begin o.src_a = 2'b01; o.src_b = 2'b01; end
         T_ALUWB:    begin o.reg_write = 1; o.done = 1; end
         T_BEQ:      begin o.src_a = 2'b10; o.alu_op = 2'b01; o.branch = 1; o.done = 1; end
         T_JAL:      begin o.src_a = 2'b01; o.src_b = 2'b10; o.pc_update = 1; end
         default: ;
      endcase
      if (in_rst) begin
         o.mem_req = 0; o.pc_update = 0; o.branch = 0; o.ir_write = 0;
         o.reg_write = 0; o.mem_write = 0; o.done = 0;
      end
      o.ill = ill;
      o.bus = bus;
      return o;
   endfunction

   function automatic logic [2:0] imm_exp(input logic [6:0] o);
      case (o)
         OP_SW:            return 3'b001;
         OP_BEQ:           return 3'b010;
         OP_JAL:           return 3'b011;
         OP_LUI, OP_AUIPC: return 3'b100;
         default:          return 3'b000;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_tests++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive one cycle and queue the expectation, then compare at the falling edge.
   task automatic step(input string tag, input tst_t sa, input tst_t sb, input logic r,
                       input logic [6:0] o);
      exp_t e;
      rdy = r;
      op  = o;
      e.tag = tag;
      e.a   = exp_out(sa, r, !rst_n, ea_ill, ea_bus);
      e.b   = exp_out(sb, r, !rst_n, eb_ill, eb_bus);
      e.imm = imm_exp(o);
      sb_q.push_back(e);
      @(negedge clk);
      e = sb_q.pop_front();
      check({e.tag, "/a"}, 32'(obs_a), 32'(e.a));
      check({e.tag, "/b"}, 32'(obs_b), 32'(e.b));
      check({e.tag, "/imm"}, 32'(if_a.ImmSrc), 32'(e.imm));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; rdy = 1'b1; op = OP_LW;
      ea_ill = 0; ea_bus = 0; eb_ill = 0; eb_bus = 0;
      repeat (2) @(posedge clk);
      #1;
      step("reset", T_FETCH, T_FETCH, 1, OP_LW);
      rst_n = 1'b1;

      // lw takes five cycles, and only MEMWB writes back.
      step("lw_fetch",   T_FETCH,   T_FETCH,   1, OP_LW);
      step("lw_decode",  T_DECODE,  T_DECODE,  1, OP_LW);
      step("lw_memadr",  T_MEMADR,  T_MEMADR,  1, OP_LW);
      step("lw_memread", T_MEMREAD, T_MEMREAD, 1, OP_LW);
      step("lw_memwb",   T_MEMWB,   T_MEMWB,   1, OP_LW);

      // sw waits three cycles in MEMWRITE. Ready arrives one stall short of the watchdog.
      step("sw_fetch",  T_FETCH,  T_FETCH,  1, OP_SW);
      step("sw_decode", T_DECODE, T_DECODE, 1, OP_SW);
      step("sw_memadr", T_MEMADR, T_MEMADR, 1, OP_SW);
      for (int i = 0; i < 3; i++) step("sw_wait", T_MEMWRITE, T_MEMWRITE, 0, OP_SW);
      step("sw_write",  T_MEMWRITE, T_MEMWRITE, 1, OP_SW);

      // R-type and I-type ALU instructions.
      step("r_fetch",  T_FETCH,  T_FETCH,  1, OP_R);
      step("r_decode", T_DECODE, T_DECODE, 1, OP_R);
      step("r_exec",   T_EXR,    T_EXR,    1, OP_R);
      step("r_wb",     T_ALUWB,  T_ALUWB,  1, OP_R);
      step("i_fetch",  T_FETCH,  T_FETCH,  1, OP_I);
      step("i_decode", T_DECODE, T_DECODE, 1, OP_I);
      step("i_exec",   T_EXI,    T_EXI,    1, OP_I);
      step("i_wb",     T_ALUWB,  T_ALUWB,  1, OP_I);

      // jal writes the PC first and then retires in ALUWB.
      step("jal_fetch",  T_FETCH,  T_FETCH,  1, OP_JAL);
      step("jal_decode", T_DECODE, T_DECODE, 1, OP_JAL);
      step("jal_jal",    T_JAL,    T_JAL,    1, OP_JAL);
      step("jal_wb",     T_ALUWB,  T_ALUWB,  1, OP_JAL);

      // beq after three fetch stalls: ready in the fourth cycle beats the watchdog.
      for (int i = 0; i < 3; i++) step("beq_fwait", T_FETCH, T_FETCH, 0, OP_BEQ);
      step("beq_fetch",  T_FETCH,  T_FETCH,  1, OP_BEQ);
      step("beq_decode", T_DECODE, T_DECODE, 1, OP_BEQ);
      step("beq_beq",    T_BEQ,    T_BEQ,    1, OP_BEQ);

      // Four fetch stalls trap dut_a with BusErr. dut_b has no watchdog and keeps waiting.
      for (int i = 0; i < 4; i++) step("wd_wait", T_FETCH, T_FETCH, 0, OP_LW);
      ea_bus = 1;
      for (int i = 0; i < 6; i++) step("wd_trap", T_TRAP, T_FETCH, 0, OP_LW);
      rst_n = 1'b0;
      step("wd_rst", T_TRAP, T_FETCH, 1, OP_LW);
      ea_bus = 0;
      rst_n = 1'b1;
      step("wd_after", T_FETCH, T_FETCH, 0, OP_LW);

      // Illegal opcode: a sticky trap that holds for 20 cycles and clears only on reset.
      step("ill_fetch",  T_FETCH,  T_FETCH,  1, OP_BAD);
      step("ill_decode", T_DECODE, T_DECODE, 1, OP_BAD);
      ea_ill = 1; eb_ill = 1;
      for (int i = 0; i < 20; i++) step("ill_trap", T_TRAP, T_TRAP, (i % 2) == 0, OP_BAD);
      rst_n = 1'b0;
      step("ill_rst", T_TRAP, T_TRAP, 1, OP_BAD);
      ea_ill = 0; eb_ill = 0;
      rst_n = 1'b1;
      step("ill_after", T_FETCH, T_FETCH, 0, OP_BAD);

      // LUI is legal only in dut_a.
      step("lui_fetch",  T_FETCH,  T_FETCH,  1, OP_LUI);
      step("lui_decode", T_DECODE, T_DECODE, 1, OP_LUI);
      eb_ill = 1;
      step("lui_exec",   T_LUI,    T_TRAP,   1, OP_LUI);
      step("lui_wb",     T_ALUWB,  T_TRAP,   1, OP_LUI);
      rst_n = 1'b0;
      step("lui_rst",    T_FETCH,  T_TRAP,   1, OP_LUI);
      eb_ill = 0;
      rst_n = 1'b1;

      // AUIPC is also legal only in dut_a.
      step("auipc_fetch",  T_FETCH,  T_FETCH,  1, OP_AUIPC);
      step("auipc_decode", T_DECODE, T_DECODE, 1, OP_AUIPC);
      eb_ill = 1;
      step("auipc_exec",   T_AUIPC,  T_TRAP,   1, OP_AUIPC);
      step("auipc_wb",     T_ALUWB,  T_TRAP,   1, OP_AUIPC);
      rst_n = 1'b0;
      step("auipc_rst",    T_FETCH,  T_TRAP,   1, OP_AUIPC);
      eb_ill = 0;
      rst_n = 1'b1;

      // Reset in MEMWRITE with ready high must suppress the store.
      step("swr_fetch",  T_FETCH,  T_FETCH,  1, OP_SW);
      step("swr_decode", T_DECODE, T_DECODE, 1, OP_SW);
      step("swr_memadr", T_MEMADR, T_MEMADR, 1, OP_SW);
      rst_n = 1'b0;
      step("swr_rst",    T_MEMWRITE, T_MEMWRITE, 1, OP_SW);
      rst_n = 1'b1;
      step("swr_after",  T_FETCH,  T_FETCH,  0, OP_SW);
      step("swr_go",     T_FETCH,  T_FETCH,  1, OP_SW);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
